pwm_setpoint_ctrl: RTL and testbench

- Sequences setpoint updates into the PWM datapath: owns the cmpA / ds_fraction registers that feed pwm.
- Accepts byte writes from i2cregif into staging registers and commits them on command.
- Applies every change only at a PWM period boundary, so no period carries a torn value.
- Optional slew limit steps cmpA toward the target by at most STEP counts per period; ds_fraction is applied together with the final step.

---
 rtl/pwm_setpoint_ctrl_pkg.sv | 24 ++
 rtl/pwm_setpoint_ctrl_if.sv | 12 +
 rtl/pwm_setpoint_ctrl_slew_step.sv | 28 ++
 rtl/pwm_setpoint_ctrl.sv | 115 +++++++++++
 tb/tb_pwm_setpoint_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_setpoint_ctrl_pkg.sv
// Shared types and constants for the PWM setpoint sequencer: FSM states,
// register map addresses and power-up setpoint values.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    RAMP    = 2'd2
  } state_t;

  localparam int unsigned REG_CMP0   = 0;
  localparam int unsigned REG_CMP1   = 1;
  localparam int unsigned REG_CMP2   = 2;
  localparam int unsigned REG_DS     = 3;
  localparam int unsigned REG_COMMIT = 4;
  localparam int unsigned REG_STEP0  = 5;
  localparam int unsigned REG_STEP1  = 6;
  localparam int unsigned REG_ABORT  = 7;

  // {16'ha000, 3'h5}: the compare value pwm starts from after power-up.
  localparam logic [18:0] RESET_CMPA = 19'h50005;
  localparam logic [7:0]  RESET_DS   = 8'h12;

endpackage

// File: rtl/pwm_setpoint_ctrl_if.sv
// Byte-wide register write bus from i2cregif. A write is accepted on every
// clk edge where regDataValid is high; there is no back-pressure (no ready).
interface pwm_setpoint_ctrl_if #(
  parameter int REGBITS = 3
);
  logic [REGBITS-1:0] regAddr;
  logic [7:0]         regData;
  logic               regDataValid;

  modport master (output regAddr, output regData, output regDataValid);
  modport slave  (input  regAddr, input  regData, input  regDataValid);
endinterface

// File: rtl/pwm_setpoint_ctrl_slew_step.sv
// One slew step of the compare value toward its target; clamps to the target
// once it is within one step, so the ramp can never overshoot or wrap.
module pwm_slew_step #(
  parameter int WIDTH = 19
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] nxt,
  output logic             done
);
  logic             up;
  logic [WIDTH-1:0] diff;

  always_comb begin
    up   = (tgt > cur);
    diff = up ? (tgt - cur) : (cur - tgt);
    // A zero step means "no slew limit": jump straight to the target.
    done = (step == '0) || (diff <= step);
    if (done) begin
      nxt = tgt;
    end else if (up) begin
      nxt = cur + step;
    end else begin
      nxt = cur - step;
    end
  end
endmodule

// File: rtl/pwm_setpoint_ctrl.sv
// Stages byte writes for cmpA/ds_fraction and applies committed values to pwm
// only on period boundaries, optionally slewing cmpA by STEP counts per period.
module pwm_setpoint_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int          WIDTH      = 19,
  parameter int          DSBITS     = 8,
  parameter int          REGBITS    = 3,
  parameter int          STEPBITS   = 16,
  parameter logic [18:0] RESET_CMPA = pwm_ctrl_pkg::RESET_CMPA,
  parameter logic [7:0]  RESET_DS   = pwm_ctrl_pkg::RESET_DS
) (
  input  logic              clk,
  input  logic              rst,
  pwm_setpoint_ctrl_if.slave reg_bus,
  input  logic              period_start,
  output logic [WIDTH-1:0]  cmpA,
  output logic [DSBITS-1:0] ds_fraction,
  output logic              dirty,
  output logic              busy,
  output logic              commit_done,
  output state_t            dbg_state
);
  localparam logic [WIDTH-1:0]  CMPA_INIT = WIDTH'(RESET_CMPA);
  localparam logic [DSBITS-1:0] DS_INIT   = RESET_DS[DSBITS-1:0];

  state_t              state_q;
  logic [WIDTH-1:0]    cmpa_q, stage_cmpa_q, tgt_cmpa_q;
  logic [DSBITS-1:0]   ds_q, stage_ds_q, tgt_ds_q;
  logic [STEPBITS-1:0] step_q;
  logic                dirty_q, done_q;

  logic             is_commit, is_abort, boundary;
  logic [WIDTH-1:0] slew_next;
  logic             slew_done;

  pwm_slew_step #(.WIDTH(WIDTH)) u_slew (
    .cur  (cmpa_q),
    .tgt  (tgt_cmpa_q),
    .step (WIDTH'(step_q)),
    .nxt  (slew_next),
    .done (slew_done)
  );

  // COMMIT and ABORT both take priority over a coincident period boundary.
  always_comb begin
    is_commit = reg_bus.regDataValid && (reg_bus.regAddr == REGBITS'(REG_COMMIT));
    is_abort  = reg_bus.regDataValid && (reg_bus.regAddr == REGBITS'(REG_ABORT));
    boundary  = period_start && (state_q != IDLE) && !is_commit && !is_abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmpa_q       <= CMPA_INIT;
      stage_cmpa_q <= CMPA_INIT;
      tgt_cmpa_q   <= CMPA_INIT;
      ds_q         <= DS_INIT;
      stage_ds_q   <= DS_INIT;
      tgt_ds_q     <= DS_INIT;
      step_q       <= '0;
      dirty_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (boundary) begin
        cmpa_q <= slew_next;
        if (slew_done) begin
          ds_q    <= tgt_ds_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end else begin
          state_q <= RAMP;
        end
      end
      if (reg_bus.regDataValid) begin
        case (reg_bus.regAddr)
          REGBITS'(REG_CMP0): begin
            stage_cmpa_q[7:0] <= reg_bus.regData;
            dirty_q           <= 1'b1;
          end
          REGBITS'(REG_CMP1): begin
            stage_cmpa_q[15:8] <= reg_bus.regData;
            dirty_q            <= 1'b1;
          end
          REGBITS'(REG_CMP2): begin
            stage_cmpa_q[WIDTH-1:16] <= reg_bus.regData[WIDTH-17:0];
            dirty_q                  <= 1'b1;
          end
          REGBITS'(REG_DS): begin
            stage_ds_q <= reg_bus.regData[DSBITS-1:0];
            dirty_q    <= 1'b1;
          end
          REGBITS'(REG_COMMIT): begin
            tgt_cmpa_q <= stage_cmpa_q;
            tgt_ds_q   <= stage_ds_q;
            dirty_q    <= 1'b0;
            state_q    <= PENDING;
          end
          REGBITS'(REG_STEP0): step_q[7:0] <= reg_bus.regData;
          REGBITS'(REG_STEP1): step_q[STEPBITS-1:8] <= reg_bus.regData[STEPBITS-9:0];
          REGBITS'(REG_ABORT): state_q <= IDLE;
          default: ;
        endcase
      end
    end
  end

  assign cmpA        = cmpa_q;
  assign ds_fraction = ds_q;
  assign dirty       = dirty_q;
  assign busy        = (state_q != IDLE);
  assign commit_done = done_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_pwm_setpoint_ctrl.sv
// Directed bench for pwm_setpoint_ctrl: every expected cmpA/ds/commit_done
// event is queued before the boundary that causes it and popped by a monitor.
module tb_pwm_setpoint_ctrl;
  import pwm_ctrl_pkg::*;

  localparam int W = 19 + 8 + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        period_start;
  logic [18:0] cmpA;
  logic [7:0]  ds_fraction;
  logic        dirty, busy, commit_done;
  state_t      dbg_state;

  pwm_setpoint_ctrl_if #(.REGBITS(3)) bus ();

  pwm_setpoint_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .reg_bus      (bus.slave),
    .period_start (period_start),
    .cmpA         (cmpA),
    .ds_fraction  (ds_fraction),
    .dirty        (dirty),
    .busy         (busy),
    .commit_done  (commit_done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_chk  = 0;
  int           n_pass = 0;
  logic         mon_en = 1'b0;
  logic [18:0]  prev_c;
  logic [7:0]   prev_d;

  function automatic logic [W-1:0] ev(logic [18:0] c, logic [7:0] d, logic done);
    return {c, d, done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && (cmpA !== prev_c || ds_fraction !== prev_d || commit_done !== 1'b0)) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output: got cmpA=0x%0h ds=0x%0h done=%0b expected no change",
                 cmpA, ds_fraction, commit_done);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({cmpA, ds_fraction, commit_done} === e) n_pass++;
        else $display("FAIL output_event: got cmpA=0x%0h ds=0x%0h done=%0b expected cmpA=0x%0h ds=0x%0h done=%0b",
                      cmpA, ds_fraction, commit_done, e[W-1:9], e[8:1], e[0]);
      end
    end
    prev_c = cmpA;
    prev_d = ds_fraction;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic ps);
    bus.regAddr      = a;
    bus.regData      = d;
    bus.regDataValid = 1'b1;
    period_start     = ps;
    idle(1);
    bus.regDataValid = 1'b0;
    period_start     = 1'b0;
  endtask

  task automatic stage(input logic [18:0] c, input logic [7:0] d);
    wr(3'(REG_CMP0), c[7:0], 1'b0);
    wr(3'(REG_CMP1), c[15:8], 1'b0);
    wr(3'(REG_CMP2), {5'b0, c[18:16]}, 1'b0);
    wr(3'(REG_DS), d, 1'b0);
  endtask

  task automatic boundary();
    period_start = 1'b1;
    idle(1);
    period_start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    period_start = 1'b0;
    bus.regAddr = '0;
    bus.regData = '0;
    bus.regDataValid = 1'b0;
    idle(3);
    rst = 1'b0;
    mon_en = 1'b1;

    // Quiet period, including boundaries while IDLE.
    idle(8); boundary(); idle(8); boundary(); idle(2);
    check("reset_cmpA", 32'(cmpA), 32'h50005);
    check("reset_ds", 32'(ds_fraction), 32'h12);
    check("reset_dirty", 32'(dirty), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));

    // Plain commit, step = 0.
    stage(19'h31234, 8'h80);
    check("stage_dirty", 32'(dirty), 1);
    check("stage_cmpA_held", 32'(cmpA), 32'h50005);
    wr(3'(REG_COMMIT), 8'h00, 1'b0);
    check("commit_dirty", 32'(dirty), 0);
    check("commit_busy", 32'(busy), 1);
    idle(3);
    check("pending_cmpA_held", 32'(cmpA), 32'h50005);
    exp_q.push_back(ev(19'h31234, 8'h80, 1'b1));
    boundary();
    check("applied_busy", 32'(busy), 0);
    idle(1);
    check("done_single_pulse", 32'(commit_done), 0);

    // Back to 0x50005, then ramp down with step 0x4000.
    stage(19'h50005, 8'h12);
    wr(3'(REG_COMMIT), 8'h00, 1'b0);
    exp_q.push_back(ev(19'h50005, 8'h12, 1'b1));
    boundary(); idle(2);
    wr(3'(REG_STEP0), 8'h00, 1'b0);
    wr(3'(REG_STEP1), 8'h40, 1'b0);
    check("step_no_dirty", 32'(dirty), 0);
    stage(19'h40000, 8'h55);
    wr(3'(REG_COMMIT), 8'h00, 1'b0);
    exp_q.push_back(ev(19'h4C005, 8'h12, 1'b0));
    exp_q.push_back(ev(19'h48005, 8'h12, 1'b0));
    exp_q.push_back(ev(19'h44005, 8'h12, 1'b0));
    exp_q.push_back(ev(19'h40005, 8'h12, 1'b0));
    exp_q.push_back(ev(19'h40000, 8'h55, 1'b1));
    for (int i = 0; i < 4; i++) begin boundary(); idle(2); end
    check("ramp_busy", 32'(busy), 1);
    check("ramp_state", 32'(dbg_state), 32'(RAMP));
    boundary(); idle(2);
    check("ramp_end_busy", 32'(busy), 0);

    // COMMIT coincident with period_start: nothing applied that period.
    stage(19'h50000, 8'h66);
    wr(3'(REG_COMMIT), 8'h00, 1'b1);
    idle(2);
    check("commit_ps_cmpA", 32'(cmpA), 32'h40000);
    check("commit_ps_state", 32'(dbg_state), 32'(PENDING));
    exp_q.push_back(ev(19'h44000, 8'h55, 1'b0));
    exp_q.push_back(ev(19'h48000, 8'h55, 1'b0));
    exp_q.push_back(ev(19'h4C000, 8'h55, 1'b0));
    exp_q.push_back(ev(19'h50000, 8'h66, 1'b1));
    for (int i = 0; i < 4; i++) begin boundary(); idle(2); end

    // Retarget mid-ramp; stage writes while busy must not leak into the target.
    stage(19'h40000, 8'h77);
    wr(3'(REG_COMMIT), 8'h00, 1'b0);
    exp_q.push_back(ev(19'h4C000, 8'h66, 1'b0));
    exp_q.push_back(ev(19'h48000, 8'h66, 1'b0));
    boundary(); idle(2); boundary(); idle(2);
    stage(19'h60000, 8'h88);
    wr(3'(REG_COMMIT), 8'h00, 1'b0);
    check("retarget_cmpA_held", 32'(cmpA), 32'h48000);
    wr(3'(REG_CMP0), 8'hFF, 1'b0);
    for (int k = 1; k <= 5; k++) exp_q.push_back(ev(19'(32'h48000 + k * 32'h4000), 8'h66, 1'b0));
    exp_q.push_back(ev(19'h60000, 8'h88, 1'b1));
    for (int i = 0; i < 6; i++) begin boundary(); idle(2); end

    // Abort mid-ramp, coincident with a boundary.
    stage(19'h50000, 8'h99);
    wr(3'(REG_COMMIT), 8'h00, 1'b0);
    exp_q.push_back(ev(19'h5C000, 8'h88, 1'b0));
    boundary(); idle(2);
    wr(3'(REG_ABORT), 8'h00, 1'b1);
    check("abort_busy", 32'(busy), 0);
    check("abort_dirty", 32'(dirty), 0);
    boundary(); idle(2); boundary(); idle(2);
    check("abort_cmpA", 32'(cmpA), 32'h5C000);
    check("abort_ds", 32'(ds_fraction), 32'h88);

    // Reset mid-ramp.
    wr(3'(REG_CMP2), 8'h04, 1'b0);
    wr(3'(REG_COMMIT), 8'h00, 1'b0);
    exp_q.push_back(ev(19'h58000, 8'h88, 1'b0));
    boundary(); idle(2);
    mon_en = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst_cmpA", 32'(cmpA), 32'h50005);
    check("rst_ds", 32'(ds_fraction), 32'h12);
    check("rst_busy", 32'(busy), 0);
    check("rst_dirty", 32'(dirty), 0);
    check("rst_done", 32'(commit_done), 0);
    idle(1);
    mon_en = 1'b1;
    boundary(); idle(2);

    // Commit of the reset staging value equals current cmpA: done at boundary.
    wr(3'(REG_COMMIT), 8'h00, 1'b0);
    exp_q.push_back(ev(19'h50005, 8'h12, 1'b1));
    boundary(); idle(4);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
